// File: rtl/uart_spi_cmd_engine.sv
`timescale 1ns / 1ps
// uart_spi_cmd_engine
//   Parses framed ASCII register commands arriving from a UART receiver,
//   issues one SPI read or write per accepted frame and sends back an ASCII
//   response through the UART transmitter.
//
//   Frame grammar:  '{' R|W ':' <ADDR_DIGITS hex> [ 'D' ':' <DATA_DIGITS hex> ] '}'
//   (the D section is present for W only).
//   Responses:      "R:<DATA_DIGITS hex>\n", "W:OK\n", "ERR\n"
//
// Ports
//   i_clk_sys, i_rst_n            system clock, asynchronous active-low reset
//   i_uart_data, i_rx_done        received byte and its one-cycle strobe
//   i_uart_idle                   transmitter idle
//   o_data_tx, o_data_valid       byte to transmit and its one-cycle strobe
//   o_spi_start                   one-cycle SPI transaction request
//   o_spi_rw                      0 = write, 1 = read
//   o_spi_addr, o_spi_wdata       SPI address / write data (held until next parse)
//   i_spi_rdata, i_spi_done       SPI read data and completion strobe
//   o_busy                        high whenever the engine is not idle
//   o_err_pulse                   one-cycle pulse on syntax error or timeout
//
// Handshakes: i_rx_done, i_spi_done, o_spi_start and o_data_valid are
// single-cycle strobes with no back-pressure. o_data_valid is only raised
// while i_uart_idle=1; the transmitter taking i_uart_idle low is treated as
// acceptance of that byte, and the next byte waits for i_uart_idle=1 again.
module uart_spi_cmd_engine #(
  parameter int SPI_ADDR_WIDTH  = 6,
  parameter int SPI_DATA_WIDTH  = 20,
  parameter int UART_DATA_WIDTH = 8,
  parameter int RX_TIMEOUT_CYC  = 50_000_000
) (
  input  logic                       i_clk_sys,
  input  logic                       i_rst_n,
  input  logic [UART_DATA_WIDTH-1:0] i_uart_data,
  input  logic                       i_rx_done,
  input  logic                       i_uart_idle,
  output logic [UART_DATA_WIDTH-1:0] o_data_tx,
  output logic                       o_data_valid,
  output logic                       o_spi_start,
  output logic                       o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0]  o_spi_addr,
  output logic [SPI_DATA_WIDTH-1:0]  o_spi_wdata,
  input  logic [SPI_DATA_WIDTH-1:0]  i_spi_rdata,
  input  logic                       i_spi_done,
  output logic                       o_busy,
  output logic                       o_err_pulse
);
  localparam int ADDR_DIGITS = (SPI_ADDR_WIDTH + 3) / 4;
  localparam int DATA_DIGITS = (SPI_DATA_WIDTH + 3) / 4;
  localparam int DATA_BITS   = DATA_DIGITS * 4;
  localparam int MAX_DIGITS  = (DATA_DIGITS > ADDR_DIGITS) ? DATA_DIGITS : ADDR_DIGITS;
  localparam int DCNT_W      = $clog2(MAX_DIGITS + 1);
  localparam int TX_W        = $clog2(DATA_DIGITS + 3);
  localparam int TO_W        = $clog2(RX_TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_COL1, S_ADDR, S_DHDR, S_COL2, S_DATA, S_CLOSE,
    S_SPI_REQ, S_SPI_WAIT, S_TX_LOAD, S_TX_WAIT
  } state_t;

  typedef enum logic [1:0] {RESP_WR, RESP_RD, RESP_ERR} resp_t;

  state_t               state_q, state_d;
  resp_t                resp_q, resp_d;
  logic [DCNT_W-1:0]    dcnt_q;
  logic [TX_W-1:0]      tx_idx_q, tx_last;
  logic [TO_W-1:0]      to_cnt_q;
  logic [DATA_BITS-1:0] rdata_q, rd_shift;
  logic [7:0]           rx_byte, tx_byte;
  logic [3:0]           hex_nib;
  logic                 hex_ok, in_parse, timeout;
  logic                 parse_ok, err_set, set_rw, rw_val, shift_addr, shift_data;
  logic                 dcnt_clr, dcnt_inc, resp_load, cap_rdata, tx_clr, tx_inc;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};  // 8'h37 + 10 = 'A'
  endfunction

  assign rx_byte  = i_uart_data[7:0];
  assign in_parse = (state_q >= S_CMD) && (state_q <= S_CLOSE);
  // A byte arriving in the expiry cycle wins: the timeout only fires on silence.
  assign timeout  = in_parse && !i_rx_done && (to_cnt_q == TO_W'(RX_TIMEOUT_CYC - 1));
  assign o_busy   = (state_q != S_IDLE);

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = 4'h0;
    if (rx_byte >= "0" && rx_byte <= "9")      hex_nib = 4'(rx_byte - "0");
    else if (rx_byte >= "A" && rx_byte <= "F") hex_nib = 4'(rx_byte - "A" + 8'd10);
    else if (rx_byte >= "a" && rx_byte <= "f") hex_nib = 4'(rx_byte - "a" + 8'd10);
    else                                       hex_ok  = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    resp_d       = RESP_ERR;
    parse_ok     = 1'b0;
    err_set      = 1'b0;
    set_rw       = 1'b0;
    rw_val       = 1'b0;
    shift_addr   = 1'b0;
    shift_data   = 1'b0;
    dcnt_clr     = 1'b0;
    dcnt_inc     = 1'b0;
    resp_load    = 1'b0;
    cap_rdata    = 1'b0;
    tx_clr       = 1'b0;
    tx_inc       = 1'b0;
    o_data_valid = 1'b0;
    o_spi_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_done && rx_byte == "{") begin
          state_d  = S_CMD;
          dcnt_clr = 1'b1;
        end
      end
      S_CMD, S_COL1, S_ADDR, S_DHDR, S_COL2, S_DATA, S_CLOSE: begin
        if (i_rx_done) begin
          if (rx_byte == "{") begin
            state_d  = S_CMD;
            dcnt_clr = 1'b1;
          end else begin
            case (state_q)
              S_CMD: begin
                if (rx_byte == "R" || rx_byte == "r" || rx_byte == "W" || rx_byte == "w") begin
                  parse_ok = 1'b1;
                  set_rw   = 1'b1;
                  rw_val   = (rx_byte == "R" || rx_byte == "r");
                  state_d  = S_COL1;
                end
              end
              S_COL1, S_COL2: begin
                if (rx_byte == ":") begin
                  parse_ok = 1'b1;
                  dcnt_clr = 1'b1;
                  state_d  = (state_q == S_COL1) ? S_ADDR : S_DATA;
                end
              end
              S_ADDR: begin
                if (hex_ok) begin
                  parse_ok   = 1'b1;
                  shift_addr = 1'b1;
                  dcnt_inc   = 1'b1;
                  if (dcnt_q == DCNT_W'(ADDR_DIGITS - 1)) begin
                    dcnt_clr = 1'b1;
                    state_d  = o_spi_rw ? S_CLOSE : S_DHDR;
                  end
                end
              end
              S_DHDR: begin
                if (rx_byte == "D" || rx_byte == "d") begin
                  parse_ok = 1'b1;
                  state_d  = S_COL2;
                end
              end
              S_DATA: begin
                if (hex_ok) begin
                  parse_ok   = 1'b1;
                  shift_data = 1'b1;
                  dcnt_inc   = 1'b1;
                  if (dcnt_q == DCNT_W'(DATA_DIGITS - 1)) begin
                    dcnt_clr = 1'b1;
                    state_d  = S_CLOSE;
                  end
                end
              end
              default: begin  // S_CLOSE
                if (rx_byte == "}") begin
                  parse_ok  = 1'b1;
                  resp_load = 1'b1;
                  resp_d    = o_spi_rw ? RESP_RD : RESP_WR;
                  state_d   = S_SPI_REQ;
                end
              end
            endcase
            if (!parse_ok) begin
              err_set   = 1'b1;
              resp_load = 1'b1;
              resp_d    = RESP_ERR;
              tx_clr    = 1'b1;
              state_d   = S_TX_LOAD;
            end
          end
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SPI_REQ: begin
        o_spi_start = 1'b1;
        state_d     = S_SPI_WAIT;
      end
      S_SPI_WAIT: begin
        if (i_spi_done) begin
          cap_rdata = o_spi_rw;
          tx_clr    = 1'b1;
          state_d   = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (i_uart_idle) begin
          o_data_valid = 1'b1;
          state_d      = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (!i_uart_idle) begin
          if (tx_idx_q == tx_last) state_d = S_IDLE;
          else begin
            tx_inc  = 1'b1;
            state_d = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response byte selection; read data is emitted most-significant digit first.
  always_comb begin
    tx_byte  = 8'h00;
    rd_shift = '0;
    case (resp_q)
      RESP_ERR: tx_last = TX_W'(3);
      RESP_WR:  tx_last = TX_W'(4);
      default:  tx_last = TX_W'(DATA_DIGITS + 2);
    endcase
    if (tx_idx_q == tx_last) tx_byte = 8'h0A;
    else if (resp_q == RESP_ERR) tx_byte = (tx_idx_q == TX_W'(0)) ? "E" : "R";
    else if (resp_q == RESP_WR) begin
      if (tx_idx_q == TX_W'(0))      tx_byte = "W";
      else if (tx_idx_q == TX_W'(1)) tx_byte = ":";
      else if (tx_idx_q == TX_W'(2)) tx_byte = "O";
      else                           tx_byte = "K";
    end else begin
      if (tx_idx_q == TX_W'(0))      tx_byte = "R";
      else if (tx_idx_q == TX_W'(1)) tx_byte = ":";
      else begin
        rd_shift = rdata_q >> (4 * (DATA_DIGITS + 1 - int'(tx_idx_q)));
        tx_byte  = hex_ascii(rd_shift[3:0]);
      end
    end
    o_data_tx = (state_q == S_TX_LOAD) ? UART_DATA_WIDTH'(tx_byte) : '0;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_pulse <= 1'b0;
      o_spi_rw    <= 1'b0;
      o_spi_addr  <= '0;
      o_spi_wdata <= '0;
      dcnt_q      <= '0;
      resp_q      <= RESP_WR;
      rdata_q     <= '0;
      tx_idx_q    <= '0;
      to_cnt_q    <= '0;
    end else begin
      o_err_pulse <= err_set;
      if (set_rw)     o_spi_rw    <= rw_val;
      // Digits shift in from the LSB end; excess high bits fall off the port.
      if (shift_addr) o_spi_addr  <= SPI_ADDR_WIDTH'({o_spi_addr, hex_nib});
      if (shift_data) o_spi_wdata <= SPI_DATA_WIDTH'({o_spi_wdata, hex_nib});
      if (dcnt_clr)      dcnt_q <= '0;
      else if (dcnt_inc) dcnt_q <= dcnt_q + 1'b1;
      if (resp_load) resp_q  <= resp_d;
      if (cap_rdata) rdata_q <= DATA_BITS'(i_spi_rdata);
      if (tx_clr)      tx_idx_q <= '0;
      else if (tx_inc) tx_idx_q <= tx_idx_q + 1'b1;
      if (!in_parse || i_rx_done) to_cnt_q <= '0;
      else                        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
endmodule
